// File: rtl/move_scheduler.sv
// move_scheduler: debounced L/R/D buttons and frame gravity arbitrated into one move command at a time.
// Optional held-button auto-repeat on frame ticks: define MOVE_SCHED_AUTOREPEAT_EN.

module move_sched_btn #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12,
  parameter int REPEAT_RATE     = 4
) (
  input  logic clk_i,
  input  logic rst_i,
`ifdef MOVE_SCHED_AUTOREPEAT_EN
  input  logic frame_tick_i,
`endif
  input  logic raw_i,
  output logic level_o,
  output logic evt_o
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("move_sched_btn: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  logic [1:0]    sync_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  logic          rise_q;

  // Counter runs only while the synchronized level disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    dcnt_d  = '0;
    if (sync_q[1] != level_q) begin
      if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) level_d = sync_q[1];
      else                                    dcnt_d  = dcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      dcnt_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
    end
  end

  assign level_o = level_q;

`ifdef MOVE_SCHED_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

  logic [RW-1:0] rpt_q, rpt_d, rpt_inc;
  logic          rpt_evt;

  // Counts ticks since press; after the first repeat it wraps back to REPEAT_DELAY.
  always_comb begin
    rpt_d   = rpt_q;
    rpt_evt = 1'b0;
    rpt_inc = rpt_q + 1'b1;
    if (!level_q || rise_q) begin
      rpt_d = '0;
    end else if (frame_tick_i) begin
      if (rpt_inc == RW'(REPEAT_DELAY)) begin
        rpt_evt = 1'b1;
        rpt_d   = rpt_inc;
      end else if (rpt_inc == RW'(REPEAT_DELAY + REPEAT_RATE)) begin
        rpt_evt = 1'b1;
        rpt_d   = RW'(REPEAT_DELAY);
      end else begin
        rpt_d   = rpt_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rpt_q <= '0;
    else       rpt_q <= rpt_d;
  end

  assign evt_o = rise_q | rpt_evt;
`else
  assign evt_o = rise_q;
`endif
endmodule

module move_scheduler #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12,
  parameter int REPEAT_RATE     = 4
) (
  input  logic       CLK25M,
  input  logic       Reset,
  input  logic       buttonL,
  input  logic       buttonR,
  input  logic       buttonD,
  input  logic       frame_tick,
  input  logic [5:0] grav_period,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic [2:0] btn_state
);
  localparam int NUM_BTN = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  logic [NUM_BTN-1:0] raw, lvl, evt;
  assign raw = {buttonD, buttonR, buttonL};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    move_sched_btn #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_btn (
      .clk_i       (CLK25M),
      .rst_i       (Reset),
`ifdef MOVE_SCHED_AUTOREPEAT_EN
      .frame_tick_i(frame_tick),
`endif
      .raw_i       (raw[i]),
      .level_o     (lvl[i]),
      .evt_o       (evt[i])
    );
  end

  assign btn_state = lvl;

  logic [7:0] fcnt_q, fcnt_d, fcnt_inc, period;
  logic       grav_evt;

  always_comb begin
    period   = (grav_period == 6'd0) ? 8'd1 : {2'b00, grav_period};
    fcnt_inc = fcnt_q + 8'd1;
    fcnt_d   = fcnt_q;
    grav_evt = 1'b0;
    if (frame_tick) begin
      if (fcnt_inc >= period) begin
        fcnt_d   = '0;
        grav_evt = 1'b1;
      end else begin
        fcnt_d   = fcnt_inc;
      end
    end
  end

  // Pending flags are indexed by command code, so lowest set index is the winner.
  logic [3:0] pend_q, pend_d, pend_set, pend_clr;
  state_t     state_q, state_d;
  logic       valid_q, valid_d;
  logic [1:0] code_q, code_d, prio;

  assign pend_set = {evt[1], evt[0], evt[2], grav_evt};

  always_comb begin
    if      (pend_q[0]) prio = 2'd0;
    else if (pend_q[1]) prio = 2'd1;
    else if (pend_q[2]) prio = 2'd2;
    else                prio = 2'd3;
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    code_d   = code_q;
    pend_clr = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          state_d = S_ISSUE;
          valid_d = 1'b1;
          code_d  = prio;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          pend_clr[code_q] = 1'b1;
          valid_d = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  always_ff @(posedge CLK25M) begin
    if (Reset) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      code_q  <= 2'd0;
      pend_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      pend_q  <= pend_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_code  = code_q;
endmodule

// File: tb/tb_move_scheduler.sv
// Randomized scoreboard bench for move_scheduler with a short debounce window.
module tb_move_scheduler;
  localparam int DEB   = 8;
  localparam int RDLY  = 12;
  localparam int RRATE = 4;

  logic       CLK25M = 1'b0;
  logic       Reset = 1'b1;
  logic       buttonL = 1'b0, buttonR = 1'b0, buttonD = 1'b0;
  logic       frame_tick = 1'b0;
  logic [5:0] grav_period = 6'd1;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic [2:0] btn_state;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];
  int fc_m = 0;

  move_scheduler #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)) dut (
    .CLK25M(CLK25M), .Reset(Reset), .buttonL(buttonL), .buttonR(buttonR), .buttonD(buttonD),
    .frame_tick(frame_tick), .grav_period(grav_period), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .btn_state(btn_state)
  );

  always #20 CLK25M = ~CLK25M;

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK25M);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Gravity rule: one event each time the tick count since the last event reaches max(period,1).
  function automatic bit grav_model();
    int p;
    p = (grav_period == 6'd0) ? 1 : int'(grav_period);
    fc_m++;
    if (fc_m >= p) begin
      fc_m = 0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    cmd_ready = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d commands outstanding after %0d cycles, expected 0", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic monitor();
    logic pv, pr, prst, phs;
    logic [1:0] pc;
    pv = 1'b0; pr = 1'b0; prst = 1'b1; phs = 1'b0; pc = 2'd0;
    forever begin
      @(negedge CLK25M);
      if (!Reset && !prst) begin
        if (phs) chk("gap_after_handshake", cmd_valid, 0);
        if (pv && !pr) begin
          chk("stall_valid_hold", cmd_valid, 1);
          chk("stall_code_hold", cmd_code, pc);
        end
        if (cmd_valid && cmd_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_cmd: got code %0d expected none", cmd_code);
          end else begin
            chk("cmd_code", cmd_code, exp_q.pop_front());
          end
        end
      end
      phs  = cmd_valid && cmd_ready && !Reset;
      pv   = cmd_valid;
      pr   = cmd_ready;
      pc   = cmd_code;
      prst = Reset;
    end
  endtask

  initial begin
    bit ev;
    int idx;
    fork
      monitor();
    join_none

    // Reset state
    Reset = 1'b1;
    step(3);
    chk("reset_valid", cmd_valid, 0);
    chk("reset_code", cmd_code, 0);
    chk("reset_btn", btn_state, 0);
    Reset = 1'b0;
    cmd_ready = 1'b1;
    step(2);

    // Debounce latency on L
    buttonL = 1'b1;
    exp_q.push_back(2'd2);
    step(9);  chk("btnL_early", btn_state[0], 0);
    step();   chk("btnL_at_10", btn_state[0], 1);
    step();   chk("valid_at_11", cmd_valid, 0);
    step();   chk("valid_at_12", cmd_valid, 1); chk("code_at_12", cmd_code, 2);
    drain(1'b0);
    buttonL = 1'b0;
    step(20);
    chk("btnL_release", btn_state, 0);

    // 5-cycle glitch must be filtered
    buttonR = 1'b1;
    step(5);
    buttonR = 1'b0;
    step(30);
    chk("glitch_btn", btn_state, 0);

    // Gravity, D and R pending together: order 0,1,3
    grav_period = 6'd1;
    buttonR = 1'b1; buttonD = 1'b1;
    step(10);
    chk("btn_RD", btn_state, 3'b110);
    frame_tick = 1'b1;
    if (grav_model()) exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    step();
    frame_tick = 1'b0;
    drain(1'b0);
    buttonR = 1'b0; buttonD = 1'b0;
    step(20);

    // Stall: gravity ticks during a held offer collapse into one command
    cmd_ready = 1'b0;
    ev = 1'b0;
    for (int f = 0; f < 3; f++) begin
      frame();
      ev |= grav_model();
      step(4);
      chk("stall_valid", cmd_valid, 1);
      chk("stall_code", cmd_code, 0);
    end
    if (ev) exp_q.push_back(2'd0);
    drain(1'b0);
    step(10);

    // Period zero behaves as period one
    grav_period = 6'd0;
    for (int k = 0; k < 5; k++) begin
      frame();
      if (grav_model()) exp_q.push_back(2'd0);
      drain(1'b1);
    end

    // Random periods with random back-pressure
    for (int k = 0; k < 16; k++) begin
      grav_period = 6'($urandom_range(0, 5));
      frame();
      if (grav_model()) exp_q.push_back(2'd0);
      step($urandom_range(0, 3));
      drain(1'b1);
    end
    step(6);

    // Random single-button presses
    for (int k = 0; k < 8; k++) begin
      idx = $urandom_range(0, 2);
      case (idx)
        0: begin buttonL = 1'b1; exp_q.push_back(2'd2); end
        1: begin buttonR = 1'b1; exp_q.push_back(2'd3); end
        default: begin buttonD = 1'b1; exp_q.push_back(2'd1); end
      endcase
      step(DEB + 6);
      chk("rand_btn_level", btn_state, 1 << idx);
      drain(1'b1);
      buttonL = 1'b0; buttonR = 1'b0; buttonD = 1'b0;
      step(DEB + 6);
    end

    // Hold D across 24 frames
    grav_period = 6'd63;
    buttonD = 1'b1;
    exp_q.push_back(2'd1);
    step(DEB + 6);
    drain(1'b1);
    for (int t = 1; t <= 24; t++) begin
      frame_tick = 1'b1;
      if (grav_model()) exp_q.push_back(2'd0);
`ifdef MOVE_SCHED_AUTOREPEAT_EN
      if (t == RDLY || (t > RDLY && (t - RDLY) % RRATE == 0)) exp_q.push_back(2'd1);
`endif
      step();
      frame_tick = 1'b0;
      step(2);
      drain(1'b1);
    end
    buttonD = 1'b0;
    step(DEB + 6);
    chk("holdD_release", btn_state, 0);

    // Reset while a command is on offer
    cmd_ready = 1'b0;
    grav_period = 6'd1;
    frame();
    ev = grav_model();
    step(3);
    chk("pre_reset_valid", cmd_valid, 1);
    Reset = 1'b1;
    step();
    chk("mid_reset_valid", cmd_valid, 0);
    chk("mid_reset_code", cmd_code, 0);
    Reset = 1'b0;
    fc_m = 0;
    cmd_ready = 1'b1;
    step(20);
    chk("post_reset_valid", cmd_valid, 0);

    step(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
